ntt_lane_serializer: RTL
========================

NTT_LANE_SERIALIZER -- requirements
Module: ntt_lane_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_PER_INPUT, default 28, giving the bit width of one coefficient.
REQ-002 The block SHALL have parameter INPUT_PER_CYCLE, default 128, giving the lanes per vector (power of two, >= 2).
REQ-003 Local LANE_WIDTH SHALL equal $clog2(INPUT_PER_CYCLE).
REQ-004 clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  a wide vector is present on in_data.
REQ-007 in_ready  output  1  the block can accept a vector this cycle.
REQ-008 in_data  input  unpacked array [INPUT_PER_CYCLE-1:0] of DATA_WIDTH_PER_INPUT  one full NTT output vector, lane i in element i.
REQ-009 out_valid  output  1  out_data holds a valid coefficient.
REQ-010 out_ready  input  1  the downstream consumer takes out_data this cycle.
REQ-011 out_data  output  DATA_WIDTH_PER_INPUT  the current serialized coefficient.
REQ-012 out_lane  output  LANE_WIDTH  the lane index of out_data.
REQ-013 out_last  output  1  high with out_valid when out_lane == INPUT_PER_CYCLE-1.

Function
REQ-014 The block SHALL hold two vector buffers (ping-pong), a write pointer wr_ptr, a read pointer rd_ptr, and a lane counter lane.
REQ-015 Occupancy state SHALL be one of EMPTY (0 full buffers), HALF (1), or FULL (2).
REQ-016 in_ready SHALL be 1 in EMPTY and HALF and 0 in FULL, derived from registered state only, with no combinational path from out_ready.
REQ-017 Accept SHALL mean in_valid && in_ready; on accept, all lanes of in_data are captured into buffer[wr_ptr] and wr_ptr toggles.
REQ-018 out_valid SHALL be 1 in HALF and FULL and 0 in EMPTY.
REQ-019 out_data SHALL equal buffer[rd_ptr][lane] when out_valid, and 0 otherwise; out_lane SHALL equal lane.
REQ-020 out_data, out_lane and out_last SHALL stay stable while out_valid && !out_ready.
REQ-021 Release SHALL mean out_valid && out_ready; on release with lane < INPUT_PER_CYCLE-1, lane increments by 1.
REQ-022 On release with lane == INPUT_PER_CYCLE-1, lane wraps to 0, rd_ptr toggles, and the vector is retired.
REQ-023 State transitions:
- EMPTY->HALF on accept.
- HALF->FULL on accept without retire.
- HALF->EMPTY on retire without accept.
- FULL->HALF on retire.
- Accept and retire in the same cycle leaves the state unchanged.
REQ-024 In FULL, a retire in the same cycle as in_valid SHALL NOT accept; in_ready rises the following cycle.
REQ-025 Latency SHALL be: lane 0 of an accepted vector presented with out_valid = 1 on the cycle after accept, when the block was EMPTY.
REQ-026 With out_ready held at 1 and vectors offered every INPUT_PER_CYCLE cycles, out_valid SHALL remain 1 continuously (no bubbles).
REQ-027 in_data SHALL be ignored when no accept occurs.

Reset
REQ-028 While rst = 1 at a clock edge, the block SHALL set:
- state EMPTY
- wr_ptr = 0, rd_ptr = 0, lane = 0
- out_valid = 0, out_data = 0, out_lane = 0, out_last = 0
- in_ready = 1 from the first cycle after reset
REQ-029 Buffer contents SHALL NOT be reset.
REQ-030 Reset mid-vector SHALL discard all held data; no partial vector is emitted afterwards.

Verification
REQ-031 Use INPUT_PER_CYCLE = 4 and DATA_WIDTH_PER_INPUT = 28, with lanes {10,11,12,13}:
- accept {10,11,12,13} with out_ready = 1 -> out_data 10,11,12,13 on cycles 1-4 after accept; out_lane 0-3; out_last only with 13; out_valid = 0 on cycle 5.
REQ-032 Backpressure:
- accept {10,11,12,13}, hold out_ready = 0 for 3 cycles, then set it to 1 -> out_data = 10 and out_lane = 0 stable through the stall, then 11,12,13.
REQ-033 Full:
- with out_ready = 0, accept {1,2,3,4} then {5,6,7,8} -> in_ready = 0.
- offer a third vector {9,9,9,9} -> not accepted.
- release 4 words -> in_ready = 1 on the cycle after the retire of 4.
- output order is 1..8.
REQ-034 Streaming:
- out_ready = 1 and a new vector offered on each retire cycle over 3 vectors -> 12 consecutive out_valid cycles with correct values.
REQ-035 Reset mid-operation:
- assert rst after 2 words of {10,11,12,13} have been released -> next cycle out_valid = 0 and in_ready = 1.
- next accept {20,21,22,23} -> first out_data = 20 with out_lane = 0.

Source files
------------

// File: rtl/ntt_lane_serializer_if.sv
// Handshake bundle between an NTT producer, the lane serializer and a
// coefficient consumer: one wide vector in, one coefficient per cycle out.
interface ntt_lane_serializer_if #(
   parameter int DATA_WIDTH_PER_INPUT = 28,
   parameter int INPUT_PER_CYCLE      = 128
);
   localparam int LANE_WIDTH = $clog2(INPUT_PER_CYCLE);

   // Both sides use valid/ready: a word moves on a rising edge where valid
   // and ready are both 1; a producer holds valid and its data until that.
   logic                            in_valid;
   logic                            in_ready;
   logic [DATA_WIDTH_PER_INPUT-1:0] in_data [INPUT_PER_CYCLE-1:0];
   logic                            out_valid;
   logic                            out_ready;
   logic [DATA_WIDTH_PER_INPUT-1:0] out_data;
   logic [LANE_WIDTH-1:0]           out_lane;
   logic                            out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_lane, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_lane, out_last
   );
endinterface

// File: rtl/ntt_lane_serializer.sv
// Ping-pong buffered serializer: captures a full NTT vector in one cycle and
// streams its coefficients out one lane per accepted handshake.
module ntt_lane_serializer #(
   parameter int DATA_WIDTH_PER_INPUT = 28,
   parameter int INPUT_PER_CYCLE      = 128
) (
   input  logic                        clk,
   input  logic                        rst,
   ntt_lane_serializer_if.slave        bus,
   output logic [1:0]                  dbg_state
);
   localparam int LANE_WIDTH = $clog2(INPUT_PER_CYCLE);
   localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(INPUT_PER_CYCLE - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                          state_q;
   state_t                          state_d;
   logic                            wr_ptr;
   logic                            rd_ptr;
   logic [LANE_WIDTH-1:0]           lane;
   logic [DATA_WIDTH_PER_INPUT-1:0] buffer [2][INPUT_PER_CYCLE];

   logic accept;
   logic release_word;
   logic retire;

   assign accept       = bus.in_valid && bus.in_ready;
   assign release_word = bus.out_valid && bus.out_ready;
   assign retire       = release_word && (lane == LAST_LANE);

   // Flow control comes only from registered occupancy, never from out_ready.
   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            bus.in_ready = 1'b1;
            if (accept) state_d = HALF;
         end
         HALF: begin
            bus.in_ready  = 1'b1;
            bus.out_valid = 1'b1;
            if (accept && !retire)      state_d = FULL;
            else if (retire && !accept) state_d = EMPTY;
         end
         FULL: begin
            bus.out_valid = 1'b1;
            if (retire) state_d = HALF;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      bus.out_data = '0;
      if (bus.out_valid) bus.out_data = buffer[rd_ptr][lane];
   end

   assign bus.out_lane = lane;
   assign bus.out_last = bus.out_valid && (lane == LAST_LANE);
   assign dbg_state    = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         lane    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) wr_ptr <= ~wr_ptr;
         if (release_word) begin
            if (lane == LAST_LANE) begin
               lane   <= '0;
               rd_ptr <= ~rd_ptr;
            end else begin
               lane <= lane + LANE_WIDTH'(1);
            end
         end
      end
   end

   // Storage carries no reset; occupancy state alone decides what is valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < INPUT_PER_CYCLE; i++) begin
            buffer[wr_ptr][i] <= bus.in_data[i];
         end
      end
   end
endmodule
